// File: rtl/lfsr_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// lfsr_gen -- parametrised Fibonacci LFSR pseudo-random generator
//
// Shifts toward the MSB; the new LSB is the XOR of every state bit selected
// by TAPS. A zero state is never allowed. A zero runtime seed, or a zero
// value produced by a non-primitive tap mask, is replaced by SEED and
// flagged on `lockup`.
//
// Optional feature macro: LFSR_WRAP_DET_EN
//   defined   : a start register, an advance counter (step_cnt), a 2-state
//               control FSM and the `wrap` pulse are built.
//   undefined : `wrap` and `step_cnt` are tied to 0. The LFSR and lock-up
//               behaviour are identical in both builds.
//
// Parameters
//   WIDTH  register width, 3..32
//   TAPS   feedback mask; bit i set => state[i] enters the XOR.
//          Must be nonzero with TAPS[WIDTH-1] = 1.
//   SEED   reset / fallback seed, must be nonzero
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   en        in   1      advance one step this cycle
//   load      in   1      load seed_in this cycle (wins over en)
//   seed_in   in   WIDTH  runtime seed
//   lfsr_out  out  WIDTH  current register state
//   lockup    out  1      one-cycle pulse: SEED substituted for a zero value
//   wrap      out  1      one-cycle pulse: state returned to the start value
//   step_cnt  out  WIDTH  advances since the last reset/load/wrap
//
// Priority on every edge: rst > load > en > hold. All outputs registered.
// ---------------------------------------------------------------------------
module lfsr_gen #(
    parameter int unsigned      WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
    parameter logic [WIDTH-1:0] SEED  = 5'b00001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] step_cnt
);

    // -----------------------------------------------------------------------
    // Next-state datapath
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] state_q;
    logic             lockup_q;

    logic             fb;
    logic [WIDTH-1:0] shift_next;
    logic             adv_zero;
    logic [WIDTH-1:0] adv_next;
    logic             load_zero;
    logic [WIDTH-1:0] load_val;

    assign fb         = ^(state_q & TAPS);
    assign shift_next = {state_q[WIDTH-2:0], fb};

    // A primitive tap mask never maps a nonzero state to zero; a
    // non-primitive one can, and the register would then stick at zero
    // forever. Substitute SEED so the generator always keeps running.
    assign adv_zero   = (shift_next == '0);
    assign adv_next   = adv_zero ? SEED : shift_next;

    // A zero runtime seed would lock the register the same way.
    assign load_zero  = (seed_in == '0);
    assign load_val   = load_zero ? SEED : seed_in;

    // -----------------------------------------------------------------------
    // LFSR state and lock-up pulse
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would make results depend on the
    // order the statements happen to be written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
        end else if (load) begin
            state_q  <= load_val;
            lockup_q <= load_zero;
        end else if (en) begin
            state_q  <= adv_next;
            lockup_q <= adv_zero;
        end else begin
            // Hold the state; the pulse lasts exactly one cycle.
            lockup_q <= 1'b0;
        end
    end

    assign lfsr_out = state_q;
    assign lockup   = lockup_q;

`ifdef LFSR_WRAP_DET_EN
    // -----------------------------------------------------------------------
    // Wrap detection: start register, advance counter, control FSM
    // -----------------------------------------------------------------------
    // START : start value captured (reset/load), no advance since.
    // RUN   : at least one advance since the capture. A return to the start
    //         value stays in RUN; only reset or load re-enter START.
    typedef enum logic {
        ST_START = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_e;

    ctrl_e            ctrl_q;
    ctrl_e            ctrl_d;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] step_cnt_q;
    logic             wrap_q;
    logic             wrap_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= ST_START;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Next-state logic
    // NOTE: the default assignment at the top of always_comb guarantees
    // every path writes ctrl_d, so no latch is inferred.
    always_comb begin
        ctrl_d = ctrl_q;
        if (load) begin
            ctrl_d = ST_START;
        end else if (en) begin
            ctrl_d = ST_RUN;
        end
    end

    // Compared against the value actually written, so a lock-up
    // substitution that lands on the start value still counts as a return.
    assign wrap_hit = (ctrl_q == ST_RUN) && (adv_next == start_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= SEED;
            step_cnt_q <= '0;
            wrap_q     <= 1'b0;
        end else if (load) begin
            start_q    <= load_val;
            step_cnt_q <= '0;
            wrap_q     <= 1'b0;
        end else if (en) begin
            wrap_q <= wrap_hit;
            // Free-running modulo 2^WIDTH when the sequence never returns.
            if (wrap_hit) begin
                step_cnt_q <= '0;
            end else begin
                step_cnt_q <= step_cnt_q + WIDTH'(1);
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign wrap     = wrap_q;
    assign step_cnt = step_cnt_q;
`else
    assign wrap     = 1'b0;
    assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
`timescale 1ns/1ps
module tb_lfsr_gen;

`ifdef LFSR_WRAP_DET_EN
    localparam bit WRAP_DET = 1'b1;
`else
    localparam bit WRAP_DET = 1'b0;
`endif

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 5-bit default instance ----------------
    logic       rst, en, load;
    logic [4:0] seed_in;
    logic [4:0] lfsr_out;
    logic       lockup, wrap;
    logic [4:0] step_cnt;

    lfsr_gen u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .seed_in  (seed_in),
        .lfsr_out (lfsr_out),
        .lockup   (lockup),
        .wrap     (wrap),
        .step_cnt (step_cnt)
    );

    // ---------------- 8-bit instance, x^8+x^6+x^5+x^4+1 ----------------
    logic       rst8, en8, load8;
    logic [7:0] seed8;
    logic [7:0] out8;
    logic       lockup8, wrap8;
    logic [7:0] step8;

    lfsr_gen #(
        .WIDTH (8),
        .TAPS  (8'hB8),
        .SEED  (8'h01)
    ) u_dut8 (
        .clk      (clk),
        .rst      (rst8),
        .en       (en8),
        .load     (load8),
        .seed_in  (seed8),
        .lfsr_out (out8),
        .lockup   (lockup8),
        .wrap     (wrap8),
        .step_cnt (step8)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent model of the default generator: new LSB = bit4 ^ bit2.
    function automatic logic [4:0] model5(input logic [4:0] v);
        return {v[3:0], v[4] ^ v[2]};
    endfunction

    // Expected step_cnt: zero when wrap detection is compiled out.
    function automatic logic [31:0] exp_sc(input int v);
        return WRAP_DET ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_wr(input bit v);
        return (WRAP_DET && v) ? 32'd1 : 32'd0;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic [4:0] seed;
        logic [4:0] exp_out;
        logic       exp_lock;
        int         exp_step;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    // watchdog: the test is a few hundred cycles long
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] v;
        logic [31:0] seen;
        int period;
        int lock_cnt;

        //            rst load en  seed      exp_out   lock step
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 0}; // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00010, 1'b0, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00100, 1'b0, 2};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b01001, 1'b0, 3};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b10010, 1'b0, 4};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b00101, 1'b0, 5};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b01011, 1'b0, 6};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 5'b00001, 1'b1, 0}; // zero seed
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 5'b00000, 5'b00001, 1'b0, 0}; // pulse ends
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'b00000, 5'b00001, 1'b1, 0}; // zero seed + en
        vecs[10] = '{1'b1, 1'b1, 1'b1, 5'b10110, 5'b00001, 1'b0, 0}; // rst wins, clears pulse
        vecs[11] = '{1'b0, 1'b1, 1'b1, 5'b10110, 5'b10110, 1'b0, 0}; // load+en: no advance
        vecs[12] = '{1'b0, 1'b0, 1'b0, 5'b00000, 5'b10110, 1'b0, 0}; // hold
        vecs[13] = '{1'b0, 1'b0, 1'b0, 5'b00000, 5'b10110, 1'b0, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 5'b00000, 5'b10110, 1'b0, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 5'b00000, 5'b01100, 1'b0, 1}; // advance from 10110
        vecs[16] = '{1'b0, 1'b1, 1'b0, 5'b10110, 5'b10110, 1'b0, 0}; // reload start

        rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;
        rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; seed8 = '0;

        // ---------- table-driven vectors ----------
        for (int i = 0; i < NVEC; i++) begin
            rst     = vecs[i].rst;
            load    = vecs[i].load;
            en      = vecs[i].en;
            seed_in = vecs[i].seed;
            step();
            check($sformatf("vec%0d_out", i),  lfsr_out, vecs[i].exp_out);
            check($sformatf("vec%0d_lock", i), lockup,   vecs[i].exp_lock);
            check($sformatf("vec%0d_step", i), step_cnt, exp_sc(vecs[i].exp_step));
            check($sformatf("vec%0d_wrap", i), wrap,     32'd0);
        end

        // ---------- 31 advances from loaded 10110: wrap at 10110 ----------
        rst = 1'b0; load = 1'b0; en = 1'b1; seed_in = '0;
        v = 5'b10110;
        for (int k = 1; k <= 31; k++) begin
            v = model5(v);
            step();
            check($sformatf("ldrun%0d_out", k), lfsr_out, v);
            check($sformatf("ldrun%0d_wrap", k), wrap, exp_wr(k == 31));
            check($sformatf("ldrun%0d_step", k), step_cnt, exp_sc((k == 31) ? 0 : k));
        end
        check("ldrun_return", lfsr_out, 5'b10110);

        // ---------- full period from reset ----------
        rst = 1'b1; en = 1'b0;
        step();
        check("per_reset_out", lfsr_out, 5'b00001);
        rst = 1'b0; en = 1'b1;
        seen = 32'd0;
        seen[1] = 1'b1;
        v = 5'b00001;
        for (int k = 1; k <= 31; k++) begin
            v = model5(v);
            step();
            check($sformatf("per%0d_out", k), lfsr_out, v);
            if (k < 31) begin
                check($sformatf("per%0d_distinct", k), seen[lfsr_out], 1'b0);
                seen[lfsr_out] = 1'b1;
            end
            check($sformatf("per%0d_wrap", k), wrap, exp_wr(k == 31));
            check($sformatf("per%0d_step", k), step_cnt, exp_sc((k == 31) ? 0 : k));
        end
        check("per_all_seen", seen, 32'hFFFF_FFFE);

        // ---------- mid-run reset ----------
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0; en = 1'b1;
        v = 5'b00001;
        for (int k = 1; k <= 12; k++) begin
            v = model5(v);
            step();
        end
        check("mid12_out", lfsr_out, v);
        check("mid12_step", step_cnt, exp_sc(12));
        rst = 1'b1; en = 1'b1;
        step();
        check("midrst_out",  lfsr_out, 5'b00001);
        check("midrst_step", step_cnt, 32'd0);
        check("midrst_wrap", wrap,     32'd0);
        check("midrst_lock", lockup,   32'd0);
        rst = 1'b0;
        step();
        check("midrst_resume_out",  lfsr_out, 5'b00010);
        check("midrst_resume_step", step_cnt, exp_sc(1));
        en = 1'b0;

        // ---------- width 8, period 255, no lock-up ----------
        rst8 = 1'b1;
        step();
        check("w8_reset_out", out8, 8'h01);
        rst8 = 1'b0; en8 = 1'b1;
        period = 0;
        lock_cnt = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (lockup8) lock_cnt++;
            if (out8 == 8'h01) begin
                period = k;
                check("w8_wrap", wrap8, exp_wr(1'b1));
                break;
            end
        end
        check("w8_period", period, 255);
        check("w8_lockups", lock_cnt, 0);
        en8 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random generator: the generalised successor of the fixed 5-bit LFSR in the DSP test-source chain. It adds configurable width, taps and reset seed, clock enable, runtime seed load, all-zero lock-up protection, and optional period/wrap detection. It feeds noise and dither sources and serves as a self-checking stimulus source for DSP benches.

## Interface
- `WIDTH`, 5: register width, legal range 3..32.
- `TAPS`, 5'b10100: feedback mask. Bit i set means state[i] enters the XOR. Must be nonzero with `TAPS[WIDTH-1]`=1. The default is x^5+x^3+1.
- `SEED`, 5'b00001: reset and fallback seed. Must be nonzero.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  advance the register one step this cycle.
- `load`  in  1  load `seed_in` this cycle.
- `seed_in`  in  WIDTH  runtime seed.
- `lfsr_out`  out  WIDTH  current register state.
- `lockup`  out  1  one-cycle pulse when a zero seed was substituted.
- `wrap`  out  1  one-cycle pulse when the state returns to the start value (`LFSR_WRAP_DET_EN` only).
- `step_cnt`  out  WIDTH  advances since the last start (`LFSR_WRAP_DET_EN` only).

## Operation
- Feedback and next state:
  - fb = XOR-reduce(state & `TAPS`).
  - next = {state[WIDTH-2:0], fb}, a shift toward the MSB.
- Per-edge priority: `rst` > `load` > `en` > hold.
  - `rst`: state=`SEED`, start=`SEED`, step_cnt=0, lockup=0, wrap=0.
  - `load` with seed_in≠0: state=seed_in, start=seed_in, step_cnt=0.
  - `load` with seed_in=0: state=`SEED`, start=`SEED`, step_cnt=0, lockup=1 for that following cycle.
  - `en` only: state=next, step_cnt+1. `load`+`en` together means load only; no advance that cycle.
  - neither: state, step_cnt and start all hold.
- Lock-up guard: the state can never be all-zero. If the combinational next value would be zero (only possible with a non-primitive `TAPS`), state=`SEED` instead and lockup pulses.
- Wrap detection:
  - On an `en` advance, if next == start, then wrap=1 for one cycle and step_cnt=0.
  - The start register holds the value captured at the last reset or load.
  - step_cnt wraps modulo 2^WIDTH silently if the taps are non-maximal and no return occurs.
- Control FSM, 2 states:
  - START: entered on reset or load; the start value has been captured but no advance has happened yet.
  - RUN: entered on the first `en` advance.
  - wrap may only fire in RUN. Returning to start forces RUN→RUN; the FSM does not go back to START.

## Timing
- All outputs are registered. `lfsr_out` reflects an `en`/`load` from the preceding edge (1-cycle latency).
- `lockup` and `wrap` are high for exactly one cycle, aligned with the `lfsr_out` value that caused them.
- `rst` asserted mid-run takes effect at the next edge. It overrides `load` and `en`, and clears any pending pulse.
- No combinational path from inputs to outputs.

## Configuration
- `LFSR_WRAP_DET_EN` defined: the start register, step_cnt, the FSM and `wrap` are implemented as above.
- `LFSR_WRAP_DET_EN` undefined:
  - `wrap` is tied to 0 and `step_cnt` is tied to 0.
  - The start register and FSM are removed.
  - LFSR and lock-up behaviour are unchanged.

## Test plan
- Reset sequence, defaults: `rst`=1 one cycle, then `en`=1.
  - Required: `lfsr_out` = 00001 → 00010 → 00100 → 01001 → 10010 → 00101 → 01011.
- Full period, defaults with `LFSR_WRAP_DET_EN`: run 31 `en` cycles.
  - Required: all 31 nonzero values are distinct; `wrap`=1 exactly when `lfsr_out` returns to 00001; `step_cnt` = 30 just before the wrap, 0 at the wrap.
- Zero seed: `load`=1 with seed_in=0.
  - Required: `lfsr_out`=00001 and `lockup`=1 for one cycle, then `lockup`=0.
- Load vs enable and hold: `load`=1, `en`=1, seed_in=10110.
  - Required: `lfsr_out`=10110 (no advance).
  - Then `en`=0 for 3 cycles: `lfsr_out` holds at 10110.
  - Then after 31 advances, `wrap` fires at 10110.
- Width 8, `TAPS`=8'hB8, `SEED`=8'h01: run 255 `en` cycles.
  - Required: period is 255 and there is no `lockup`.
- Mid-run reset: after 12 advances, `rst` and `en` both =1.
  - Required: `lfsr_out`=`SEED`, `step_cnt`=0, `wrap`=0 on the next cycle.
